// File: rtl/mac_pkg.sv
// Shared constants and width helpers for the mac_pipe dot-product engine.
// Saturation behaviour is selected with the MAC_PIPE_SAT_EN macro.
package mac_pkg;

    localparam int IWIDTH_DEF = 8;
    localparam int GUARD_DEF  = 8;

    // Clip limits of the default Q1.15 result
    localparam logic [15:0] SAT_MAX_DEF = 16'h7FFF;
    localparam logic [15:0] SAT_MIN_DEF = 16'h8000;

    function automatic int owidth(input int iw);
        return 2 * iw;
    endfunction

    function automatic int accw(input int iw, input int guard);
        return 2 * iw + guard;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational Q2 -> Q1 narrowing of the accumulator sum to the result width.
// MAC_PIPE_SAT_EN defined: clip with flag; undefined: two's-complement wrap.
module mac_sat #(
    parameter int ACCW   = 24,
    parameter int OWIDTH = 16
) (
    input  logic signed [ACCW-1:0]   sum,
    output logic        [OWIDTH-1:0] data,
    output logic                     sat
);

    logic [ACCW:0] shifted_s;

    assign shifted_s = {sum, 1'b0};

`ifdef MAC_PIPE_SAT_EN
    logic [ACCW-OWIDTH+1:0] hi_s;

    assign hi_s = shifted_s[ACCW:OWIDTH-1];

    // Clip when the bits above the result sign are not a pure sign extension
    always_comb begin
        data = shifted_s[OWIDTH-1:0];
        sat  = 1'b0;
        if (!((&hi_s) || (~|hi_s))) begin
            sat  = 1'b1;
            data = shifted_s[ACCW] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                   : {1'b0, {(OWIDTH-1){1'b1}}};
        end else begin
            sat  = 1'b0;
        end
    end
`else
    logic unused_hi_s;

    assign unused_hi_s = ^shifted_s[ACCW:OWIDTH];
    assign data        = shifted_s[OWIDTH-1:0];
    assign sat         = 1'b0;
`endif

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined signed multiply-accumulate producing one dot product per in_last.
// MAC_PIPE_SAT_EN enables accumulator/result saturation and the out_sat flag.
module mac_pipe
    import mac_pkg::*;
#(
    parameter  int IWIDTH = IWIDTH_DEF,
    parameter  int GUARD  = GUARD_DEF,
    localparam int OWIDTH = owidth(IWIDTH),
    localparam int ACCW   = accw(IWIDTH, GUARD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IWIDTH-1:0] a,
    input  logic signed [IWIDTH-1:0] b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [OWIDTH-1:0] out_data,
    output logic                     out_sat
);

    logic                     adv_s;
    logic                     accept_s;
    logic signed [OWIDTH-1:0] s1_prod_r;
    logic                     s1_valid_r;
    logic                     s1_last_r;
    logic signed [ACCW-1:0]   acc_r;
    logic                     first_r;
    logic signed [ACCW-1:0]   base_s;
    logic signed [ACCW-1:0]   prod_ext_s;
    logic signed [ACCW-1:0]   sum_s;
    logic                     vec_ovf_s;
    logic        [OWIDTH-1:0] nar_data_s;
    logic                     nar_sat_s;
    logic                     out_valid_r;
    logic        [OWIDTH-1:0] out_data_r;
    logic                     out_sat_r;

    assign adv_s     = !(out_valid_r && !out_ready);
    assign accept_s  = in_valid && adv_s;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

    // Stage 1: capture the exact product of an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_prod_r  <= '0;
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_prod_r <= a * b;
                s1_last_r <= in_last;
            end
        end
    end

`ifdef MAC_PIPE_SAT_EN
    localparam int ACCW1 = ACCW + 1;
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    logic signed [ACCW:0] wide_s;
    logic                 acc_ovf_s;
    logic                 ovf_r;

    // Accumulate with one extra bit so an ACCW overflow can be clipped and remembered
    always_comb begin
        base_s     = first_r ? '0 : acc_r;
        prod_ext_s = ACCW'(s1_prod_r);
        wide_s     = ACCW1'(base_s) + ACCW1'(prod_ext_s);
        if (wide_s[ACCW] != wide_s[ACCW-1]) begin
            acc_ovf_s = 1'b1;
            sum_s     = wide_s[ACCW] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_ovf_s = 1'b0;
            sum_s     = wide_s[ACCW-1:0];
        end
        vec_ovf_s = acc_ovf_s || (ovf_r && !first_r);
    end

    // Sticky overflow flag for the vector in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (adv_s && s1_valid_r) begin
            ovf_r <= s1_last_r ? 1'b0 : vec_ovf_s;
        end
    end
`else
    // Plain wrapping accumulation
    always_comb begin
        base_s     = first_r ? '0 : acc_r;
        prod_ext_s = ACCW'(s1_prod_r);
        sum_s      = base_s + prod_ext_s;
        vec_ovf_s  = 1'b0;
    end
`endif

    mac_sat #(
        .ACCW   (ACCW),
        .OWIDTH (OWIDTH)
    ) u_sat (
        .sum  (sum_s),
        .data (nar_data_s),
        .sat  (nar_sat_s)
    );

    // Stage 2: accumulate, or publish the narrowed result on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            first_r     <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r && s1_last_r;
            if (s1_valid_r && s1_last_r) begin
                acc_r      <= '0;
                first_r    <= 1'b1;
                out_data_r <= nar_data_s;
                out_sat_r  <= nar_sat_s || vec_ovf_s;
            end else if (s1_valid_r) begin
                acc_r   <= sum_s;
                first_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed self-checking bench for mac_pipe (IWIDTH=8, GUARD=8); expectations follow MAC_PIPE_SAT_EN.
module tb_mac_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[7];

    mac_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Offer one beat before the next rising edge; returns 1 time unit after that edge
    task automatic beat(input logic [7:0] ia, input logic [7:0] ib, input logic il);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        in_last  = il;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{8'h40, 8'h40, 16'h2000, 1'b0};
`ifdef MAC_PIPE_SAT_EN
        vecs[1] = '{8'h80, 8'h80, 16'h7FFF, 1'b1};
`else
        vecs[1] = '{8'h80, 8'h80, 16'h8000, 1'b0};
`endif
        vecs[2] = '{8'h7F, 8'h7F, 16'h7E02, 1'b0};
        vecs[3] = '{8'h80, 8'h7F, 16'h8100, 1'b0};
        vecs[4] = '{8'hFF, 8'h01, 16'hFFFE, 1'b0};
        vecs[5] = '{8'h00, 8'h55, 16'h0000, 1'b0};
        vecs[6] = '{8'hC0, 8'h40, 16'hE000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-beat vectors: result visible in the second cycle after the accepting edge
        for (int i = 0; i < 7; i++) begin
            beat(vecs[i].a, vecs[i].b, 1'b1);
            chk("tbl_early_valid", 32'(out_valid), 32'd0);
            idle_cycle();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_data", 32'(out_data), 32'(vecs[i].exp_data));
            chk("tbl_sat", 32'(out_sat), 32'(vecs[i].exp_sat));
            idle_cycle();
            chk("tbl_consumed", 32'(out_valid), 32'd0);
        end

        // Three back-to-back beats form one result
        for (int i = 0; i < 3; i++) begin
            beat(8'h40, 8'h40, (i == 2) ? 1'b1 : 1'b0);
            chk("acc3_no_early", 32'(out_valid), 32'd0);
        end
        idle_cycle();
        chk("acc3_valid", 32'(out_valid), 32'd1);
        chk("acc3_data", 32'(out_data), 32'h6000);
        idle_cycle();
        chk("acc3_once", 32'(out_valid), 32'd0);

        // Two-beat sum that exceeds the result range
        beat(8'h7F, 8'h7F, 1'b0);
        beat(8'h7F, 8'h7F, 1'b1);
        idle_cycle();
        chk("clip_valid", 32'(out_valid), 32'd1);
`ifdef MAC_PIPE_SAT_EN
        chk("clip_data", 32'(out_data), 32'h7FFF);
        chk("clip_sat", 32'(out_sat), 32'd1);
`else
        chk("clip_data", 32'(out_data), 32'hFC04);
        chk("clip_sat", 32'(out_sat), 32'd0);
`endif
        idle_cycle();

        // Back-pressure: pending result holds and the offered beat waits
        out_ready = 1'b0;
        beat(8'h40, 8'h40, 1'b1);
        idle_cycle();
        chk("stall_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            beat(8'h20, 8'h40, 1'b1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_data", 32'(out_data), 32'h2000);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", 32'(out_valid), 32'd0);
        idle_cycle();
        chk("stall_next_valid", 32'(out_valid), 32'd1);
        chk("stall_next_data", 32'(out_data), 32'h1000);
        idle_cycle();
        chk("stall_no_dup", 32'(out_valid), 32'd0);

        // Reset in the middle of a four-beat vector
        beat(8'h40, 8'h40, 1'b0);
        beat(8'h40, 8'h40, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_quiet", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        beat(8'h40, 8'h40, 1'b1);
        idle_cycle();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h2000);
        idle_cycle();

        // Back-to-back vectors: second result replaces the first on the next edge
        beat(8'h40, 8'h40, 1'b0);
        beat(8'h40, 8'h40, 1'b1);
        beat(8'h7F, 8'h7F, 1'b1);
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_data", 32'(out_data), 32'h4000);
        idle_cycle();
        chk("b2b_second_valid", 32'(out_valid), 32'd1);
        chk("b2b_second_data", 32'(out_data), 32'h7E02);
        idle_cycle();
        chk("b2b_done", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
